// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB from a latched
// opcode, stalls on mem_ready, drives datapath strobes and counts retirements.
module unidad_control_multiciclo #(
    parameter int OP_WIDTH    = 6,
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   IRWrite,
    output logic                   MemRead,
    output logic                   MemToWrite,
    output logic                   MemToReg,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic                   ALUSrc,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   illegal_op,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [OP_WIDTH-1:0]   op_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  illegal_r;
    logic                  retire_s;

    logic                  pc_write_s;
    logic                  ir_write_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic                  mem_to_reg_s;
    logic                  reg_write_s;
    logic                  reg_dst_s;
    logic                  alu_src_s;
    logic [2:0]            alu_op_s;

    function automatic logic goes_to_exec(input logic [OP_WIDTH-1:0] opc);
        return (opc == OP_R) || (opc == OP_LW) || (opc == OP_SW) ||
               (opc == OP_BEQ) || (opc == OP_ADDI);
    endfunction

    // State, latched opcode, retire counter and sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_r      <= '0;
            count_r   <= '0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (en && (state_r == S_DECODE)) begin
                op_r <= op;
            end
            if (retire_s) begin
                count_r <= count_r + CNT_WIDTH'(1);
            end
            if (state_nxt_s == S_TRAP) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state and retire decision; everything holds while en is low.
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        if (en) begin
            case (state_r)
                S_IDLE:   state_nxt_s = S_FETCH;
                S_FETCH: begin
                    if (mem_ready) state_nxt_s = S_DECODE;
                    else           state_nxt_s = S_FETCH;
                end
                S_DECODE: begin
                    if (op == OP_J) begin
                        state_nxt_s = S_FETCH;
                        retire_s    = 1'b1;
                    end else if (goes_to_exec(op)) begin
                        state_nxt_s = S_EXEC;
                    end else begin
                        state_nxt_s = S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (op_r)
                        OP_R, OP_ADDI: state_nxt_s = S_WB;
                        OP_LW, OP_SW:  state_nxt_s = S_MEM;
                        OP_BEQ: begin
                            state_nxt_s = S_FETCH;
                            retire_s    = 1'b1;
                        end
                        default:       state_nxt_s = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    if (!mem_ready) begin
                        state_nxt_s = S_MEM;
                    end else if (op_r == OP_LW) begin
                        state_nxt_s = S_WB;
                    end else begin
                        state_nxt_s = S_FETCH;
                        retire_s    = 1'b1;
                    end
                end
                S_WB: begin
                    state_nxt_s = S_FETCH;
                    retire_s    = 1'b1;
                end
                S_TRAP:   state_nxt_s = S_TRAP;
                default:  state_nxt_s = S_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Datapath strobes; memory requests and writes are gated by en.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        alu_src_s    = 1'b0;
        alu_op_s     = 3'b000;
        case (state_r)
            S_FETCH: begin
                mem_read_s = en;
                ir_write_s = en & mem_ready;
                pc_write_s = en & mem_ready;
            end
            // J is resolved before op_r is loaded, so look at the live opcode.
            S_DECODE: pc_write_s = en & (op == OP_J);
            S_EXEC: begin
                case (op_r)
                    OP_R:                alu_op_s = 3'b010;
                    OP_LW, OP_SW, OP_ADDI: alu_src_s = 1'b1;
                    OP_BEQ: begin
                        alu_op_s   = 3'b001;
                        pc_write_s = en & zero;
                    end
                    default:             alu_op_s = 3'b000;
                endcase
            end
            S_MEM: begin
                if (op_r == OP_LW) mem_read_s  = en;
                else               mem_write_s = en;
            end
            S_WB: begin
                reg_write_s  = en;
                reg_dst_s    = (op_r == OP_R);
                mem_to_reg_s = (op_r == OP_LW);
            end
            default: pc_write_s = 1'b0;
        endcase
    end

    assign PCWrite     = pc_write_s;
    assign IRWrite     = ir_write_s;
    assign MemRead     = mem_read_s;
    assign MemToWrite  = mem_write_s;
    assign MemToReg    = mem_to_reg_s;
    assign RegWrite    = reg_write_s;
    assign RegDst      = reg_dst_s;
    assign ALUSrc      = alu_src_s;
    assign ALUOp       = ALUOP_WIDTH'(alu_op_s);
    assign illegal_op  = illegal_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: per-cycle expected strobes are
// queued as stimulus is applied and compared against the DUT mid-cycle.
module tb_unidad_control_multiciclo;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemRead, MemToWrite, MemToReg;
    logic       RegWrite, RegDst, ALUSrc, illegal_op;
    logic [2:0] ALUOp;
    logic [3:0] instr_count;

    int checks;
    int fails;

    unidad_control_multiciclo #(
        .OP_WIDTH(6), .ALUOP_WIDTH(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemToWrite(MemToWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: PCW IRW MR | MW M2R RW RD AS | ALUOp
    localparam logic [10:0] C_NONE    = 11'b000_00000_000;
    localparam logic [10:0] C_FETCH   = 11'b111_00000_000;
    localparam logic [10:0] C_DEC_J   = 11'b100_00000_000;
    localparam logic [10:0] C_EX_R    = 11'b000_00000_010;
    localparam logic [10:0] C_EX_I    = 11'b000_00001_000;
    localparam logic [10:0] C_EX_BEQ0 = 11'b000_00000_001;
    localparam logic [10:0] C_EX_BEQ1 = 11'b100_00000_001;
    localparam logic [10:0] C_MEM_LW  = 11'b001_00000_000;
    localparam logic [10:0] C_MEM_SW  = 11'b000_10000_000;
    localparam logic [10:0] C_WB_R    = 11'b000_00110_000;
    localparam logic [10:0] C_WB_I    = 11'b000_00100_000;
    localparam logic [10:0] C_WB_LW   = 11'b000_01100_000;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    task automatic cyc(input string tag, input logic [10:0] ctl,
                       input logic ill, input logic [3:0] cnt);
        exp_t        e;
        logic [15:0] obs;
        e.tag = tag;
        e.exp = {ctl, ill, cnt};
        sb.push_back(e);
        #1;
        obs = {PCWrite, IRWrite, MemRead, MemToWrite, MemToReg, RegWrite,
               RegDst, ALUSrc, ALUOp, illegal_op, instr_count};
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n = 1'b0; en = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        #2;
        cyc("reset", C_NONE, 1'b0, 4'd0);
        rst_n = 1'b1;
        cyc("idle_en0", C_NONE, 1'b0, 4'd0);
        en = 1'b1;
        cyc("idle", C_NONE, 1'b0, 4'd0);

        // R-type, zero-wait memory
        cyc("r_fetch", C_FETCH, 1'b0, 4'd0);
        cyc("r_dec",   C_NONE,  1'b0, 4'd0);
        cyc("r_exec",  C_EX_R,  1'b0, 4'd0);
        cyc("r_wb",    C_WB_R,  1'b0, 4'd0);

        // LW with three stall cycles in MEM
        op = 6'b100011;
        cyc("lw_fetch", C_FETCH, 1'b0, 4'd1);
        cyc("lw_dec",   C_NONE,  1'b0, 4'd1);
        cyc("lw_exec",  C_EX_I,  1'b0, 4'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", C_MEM_LW, 1'b0, 4'd1);
        mem_ready = 1'b1;
        cyc("lw_mem",   C_MEM_LW, 1'b0, 4'd1);
        cyc("lw_wb",    C_WB_LW,  1'b0, 4'd1);

        // SW with three stall cycles
        op = 6'b101011;
        cyc("sw_fetch", C_FETCH, 1'b0, 4'd2);
        cyc("sw_dec",   C_NONE,  1'b0, 4'd2);
        cyc("sw_exec",  C_EX_I,  1'b0, 4'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_mem_wait", C_MEM_SW, 1'b0, 4'd2);
        mem_ready = 1'b1;
        cyc("sw_mem",   C_MEM_SW, 1'b0, 4'd2);

        // BEQ taken then not taken
        op = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch", C_FETCH,   1'b0, 4'd3);
        cyc("beq1_dec",   C_NONE,    1'b0, 4'd3);
        cyc("beq1_exec",  C_EX_BEQ1, 1'b0, 4'd3);
        zero = 1'b0;
        cyc("beq0_fetch", C_FETCH,   1'b0, 4'd4);
        cyc("beq0_dec",   C_NONE,    1'b0, 4'd4);
        cyc("beq0_exec",  C_EX_BEQ0, 1'b0, 4'd4);

        // ADDI
        op = 6'b001000;
        cyc("addi_fetch", C_FETCH, 1'b0, 4'd5);
        cyc("addi_dec",   C_NONE,  1'b0, 4'd5);
        cyc("addi_exec",  C_EX_I,  1'b0, 4'd5);
        cyc("addi_wb",    C_WB_I,  1'b0, 4'd5);

        // Freeze in FETCH with memory ready, then a J
        op = 6'b000010; en = 1'b0;
        cyc("freeze0", C_NONE, 1'b0, 4'd6);
        cyc("freeze1", C_NONE, 1'b0, 4'd6);
        en = 1'b1;
        cyc("j_fetch", C_FETCH, 1'b0, 4'd6);
        cyc("j_dec",   C_DEC_J, 1'b0, 4'd6);

        // Asynchronous reset in the middle of an R-type EXEC
        op = 6'b000000;
        cyc("r2_fetch", C_FETCH, 1'b0, 4'd7);
        cyc("r2_dec",   C_NONE,  1'b0, 4'd7);
        rst_n = 1'b0;
        cyc("rst_mid_exec", C_NONE, 1'b0, 4'd0);
        rst_n = 1'b1;
        cyc("post_rst_idle", C_NONE, 1'b0, 4'd0);

        // Sixteen J instructions wrap the 4-bit counter
        op = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            cyc("wrap_fetch", C_FETCH, 1'b0, 4'(i));
            cyc("wrap_dec",   C_DEC_J, 1'b0, 4'(i));
        end

        // Illegal opcode traps permanently
        op = 6'b000001;
        cyc("ill_fetch", C_FETCH, 1'b0, 4'd0);
        cyc("ill_dec",   C_NONE,  1'b0, 4'd0);
        op = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            zero      = 1'(i % 2);
            mem_ready = 1'((i / 2) % 2);
            cyc("trap", C_NONE, 1'b1, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
